sc_stream_mul: RTL and testbench

- Stochastic-computing multiplier that sits directly downstream of the Weyl bitstream table.
- Accepts two BITSTREAM-wide parallel unary bitstreams (two table instances with different BASE/STRIDE), combines them bitwise over BITSTREAM/CHUNK cycles, and popcounts the result.
- The product count uses the same width and encoding as the table's quota input, so it can be fed back as a new quota.

---
 rtl/sc_stream_mul.sv | 169 ++++++++++++++++
 tb/tb_sc_stream_mul.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_mul.sv
// sc_stream_mul: stochastic-computing multiplier; popcounts the bitwise combine of two
// parallel unary bitstreams CHUNK bits per cycle. Optional macro: SC_MUL_BIPOLAR_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | accumulating the popcount of one CHUNK of the combined stream per cycle
// DONE  | product held on the output until the consumer takes it
module sc_stream_mul #(
  parameter int BITSTREAM = 64,
  parameter int CHUNK     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef SC_MUL_BIPOLAR_EN
  input  logic                       bipolar,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITSTREAM-1:0]       stream_a,
  input  logic [BITSTREAM-1:0]       stream_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(BITSTREAM):0] product,
  output logic                       busy
);

  localparam int NCHUNK = BITSTREAM / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = $clog2(BITSTREAM) + 1;
  localparam int PC_W   = $clog2(CHUNK) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (CHUNK < 1 || BITSTREAM < CHUNK || (BITSTREAM % CHUNK) != 0) begin : g_param_err
    $error("sc_stream_mul: BITSTREAM must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BITSTREAM-1:0] a_q, a_d;
  logic [BITSTREAM-1:0] b_q, b_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        product_q, product_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
`ifdef SC_MUL_BIPOLAR_EN
  logic                 bipolar_q, bipolar_d;
`endif

  logic [BITSTREAM-1:0] comb_w;
  logic [CHUNK-1:0]     chunk_w;
  logic [PC_W-1:0]      pc_w;
  logic [PW-1:0]        sum_w;

  always_comb begin
`ifdef SC_MUL_BIPOLAR_EN
    comb_w = bipolar_q ? ~(a_q ^ b_q) : (a_q & b_q);
`else
    comb_w = a_q & b_q;
`endif
  end

  always_comb begin
    chunk_w = comb_w[int'(idx_q) * CHUNK +: CHUNK];
    pc_w    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pc_w = pc_w + PC_W'(chunk_w[i]);
    end
    sum_w = acc_q + PW'(pc_w);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
`ifdef SC_MUL_BIPOLAR_EN
    bipolar_d   = bipolar_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = stream_a;
          b_d        = stream_b;
`ifdef SC_MUL_BIPOLAR_EN
          bipolar_d  = bipolar;
`endif
          idx_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = sum_w;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          product_d   = sum_w;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // a new operand offered alongside the handshake waits for the next IDLE cycle
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SC_MUL_BIPOLAR_EN
      bipolar_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef SC_MUL_BIPOLAR_EN
      bipolar_q   <= bipolar_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sc_stream_mul.sv
// tb_sc_stream_mul: directed vector table plus hand-written handshake, backpressure,
// operand-toggle and mid-operation reset sequences for sc_stream_mul.
module tb_sc_stream_mul;

  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZEROS = 64'h0;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] stream_a;
  logic [63:0] stream_b;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  product;
  logic        busy;
`ifdef SC_MUL_BIPOLAR_EN
  logic        bipolar;
`endif

  int n_pass;
  int n_total;

  sc_stream_mul #(.BITSTREAM(64), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SC_MUL_BIPOLAR_EN
    .bipolar   (bipolar),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .stream_a  (stream_a),
    .stream_b  (stream_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bip;
    logic [6:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, returning the number of edges seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bip,
                        input logic [6:0] exp, input string name);
    int lat;
    check({name, " in_ready before"}, {63'd0, in_ready}, 64'd1);
    stream_a = a;
    stream_b = b;
`ifdef SC_MUL_BIPOLAR_EN
    bipolar  = bip;
`else
    if (bip) $display("note: bipolar vector %s run without bipolar support", name);
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    stream_a = ~a;
    stream_b = ~b;
`ifdef SC_MUL_BIPOLAR_EN
    bipolar  = ~bip;
`endif
    check({name, " busy in run"}, {63'd0, busy}, 64'd1);
    wait_out(lat);
    check({name, " latency"}, 64'(lat), 64'd8);
    check({name, " product"}, {57'd0, product}, {57'd0, exp});
    check({name, " in_ready in done"}, {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid after hs"}, {63'd0, out_valid}, 64'd0);
    check({name, " in_ready after hs"}, {63'd0, in_ready}, 64'd1);
    check({name, " busy after hs"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stream_a  = ZEROS;
    stream_b  = ZEROS;
`ifdef SC_MUL_BIPOLAR_EN
    bipolar   = 1'b0;
`endif

    vecs.push_back('{ONES, ONES, 1'b0, 7'd64, "all_ones"});
    vecs.push_back('{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b0, 7'd0, "disjoint"});
    vecs.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_FFFF_0000, 1'b0, 7'd16, "alt_mask"});
    vecs.push_back('{ZEROS, ZEROS, 1'b0, 7'd0, "all_zero"});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, ONES, 1'b0, 7'd32, "hex_ramp"});
    vecs.push_back('{64'h8000_0000_0000_0001, ONES, 1'b0, 7'd2, "end_bits"});
    vecs.push_back('{64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 1'b0, 7'd8, "top_chunk"});
`ifdef SC_MUL_BIPOLAR_EN
    vecs.push_back('{ONES, ZEROS, 1'b1, 7'd0, "bip_ones_zeros"});
    vecs.push_back('{64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1, 7'd64, "bip_same"});
    vecs.push_back('{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 7'd0, "bip_opposite"});
    vecs.push_back('{64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b0, 7'd32, "uni_same"});
    vecs.push_back('{ZEROS, ZEROS, 1'b1, 7'd64, "bip_zeros"});
`endif

    tick();
    tick();
    rst_n = 1'b1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset product", {57'd0, product}, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset busy", {63'd0, busy}, 64'd0);

    // out_ready outside DONE must not disturb the idle block
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle out_ready in_ready", {63'd0, in_ready}, 64'd1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].bip, vecs[i].exp, vecs[i].name);

    // backpressure: product held through 5 stalled cycles, in_valid pulses ignored
    stream_a = ONES;
    stream_b = ONES;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp latency", 64'(lat), 64'd8);
    for (int c = 0; c < 5; c++) begin
      stream_a = ZEROS;
      stream_b = ZEROS;
      in_valid = c[0];
      tick();
      check("bp out_valid", {63'd0, out_valid}, 64'd1);
      check("bp product", {57'd0, product}, 64'd64);
      check("bp in_ready", {63'd0, in_ready}, 64'd0);
    end
    // in_valid and out_ready together in DONE: only the output handshake completes
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dual out_valid", {63'd0, out_valid}, 64'd0);
    check("dual in_ready", {63'd0, in_ready}, 64'd1);
    check("dual busy", {63'd0, busy}, 64'd0);
    tick();
    in_valid = 1'b0;
    check("dual accept busy", {63'd0, busy}, 64'd1);
    wait_out(lat);
    check("dual latency", 64'(lat), 64'd8);
    check("dual product", {57'd0, product}, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // inputs toggling during RUN with in_valid and out_ready high must not affect the result
    stream_a = 64'hAAAA_AAAA_AAAA_AAAA;
    stream_b = 64'hFFFF_0000_FFFF_0000;
    in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      stream_a  = lat[0] ? ONES : ZEROS;
      stream_b  = lat[0] ? ZEROS : ONES;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("toggle latency", 64'(lat), 64'd8);
    check("toggle product", {57'd0, product}, 64'd16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset during chunk 3 discards the operation
    stream_a = ONES;
    stream_b = ONES;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst product", {57'd0, product}, 64'd0);
    check("midrst in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst busy", {63'd0, busy}, 64'd0);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) lat++;
    end
    check("midrst no output", 64'(lat), 64'd0);
    run_op(ONES, ONES, 1'b0, 7'd64, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
